// File: rtl/regfile_wr_arb.sv
// -----------------------------------------------------------------------------
// regfile_wr_arb
//
// Round-robin write-port arbiter for the register file. N_REQ writeback
// requesters (functional units, load return, ...) present valid/ready write
// requests. Up to N_WRITE_PORTS of them are granted per cycle, and no two
// grants in one cycle target the same entry. The granted writes are registered
// and drive the regfile write ports one cycle after acceptance.
//
// Optional feature (compile-time macro REGFILE_WR_ARB_STARVE_EN):
//   Each requester gets a saturating wait counter. A requester that has waited
//   STARVE_LIMIT or more cycles is scanned ahead of all non-starved requesters.
//   Without the macro the arbiter is pure round-robin and has no counters.
//
// Ports:
//   clk        in   clock, rising-edge active
//   rst_aL     in   asynchronous active-low reset
//   req_valid  in   [N_REQ]                 requester has a write pending
//   req_addr   in   [N_REQ][PTR_WIDTH]      destination entry per requester
//   req_data   in   [N_REQ][ENTRY_WIDTH]    write data per requester
//   req_ready  out  [N_REQ]                 combinational grant
//   wr_en      out  [N_WRITE_PORTS]         registered regfile write enables
//   wr_addr    out  [N_WRITE_PORTS][PTR_WIDTH]    registered write addresses
//   wr_data    out  [N_WRITE_PORTS][ENTRY_WIDTH]  registered write data
// -----------------------------------------------------------------------------
module regfile_wr_arb #(
    parameter int ENTRY_WIDTH   = 32,
    parameter int N_ENTRIES     = 32,
    parameter int N_REQ         = 4,
    parameter int N_WRITE_PORTS = 2,
    parameter int STARVE_LIMIT  = 8,
    localparam int PTR_WIDTH    = $clog2(N_ENTRIES)
) (
    input  logic                                      clk,
    input  logic                                      rst_aL,
    input  logic [N_REQ-1:0]                          req_valid,
    input  logic [N_REQ-1:0][PTR_WIDTH-1:0]           req_addr,
    input  logic [N_REQ-1:0][ENTRY_WIDTH-1:0]         req_data,
    output logic [N_REQ-1:0]                          req_ready,
    output logic [N_WRITE_PORTS-1:0]                  wr_en,
    output logic [N_WRITE_PORTS-1:0][PTR_WIDTH-1:0]   wr_addr,
    output logic [N_WRITE_PORTS-1:0][ENTRY_WIDTH-1:0] wr_data
);

    localparam int RR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // Reject configurations the arbiter cannot serve.
    if (N_WRITE_PORTS < 1 || N_WRITE_PORTS > N_REQ || STARVE_LIMIT < 1) begin : g_bad_cfg
        $error("regfile_wr_arb: illegal parameter combination");
    end

    logic [RR_W-1:0]                          rr_ptr_q, rr_ptr_d;
    logic [N_WRITE_PORTS-1:0]                 wr_en_q, wr_en_d;
    logic [N_WRITE_PORTS-1:0][PTR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
    logic [N_WRITE_PORTS-1:0][ENTRY_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [N_REQ-1:0]                         req_ready_s;
    logic [N_REQ-1:0]                         starved_s;

`ifdef REGFILE_WR_ARB_STARVE_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [N_REQ-1:0][CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    // Starved flags and saturating wait-counter next state.
    always_comb begin
        starved_s  = '0;
        wait_cnt_d = wait_cnt_q;
        for (int r = 0; r < N_REQ; r++) begin
            starved_s[r] = (wait_cnt_q[r] >= CNT_W'(STARVE_LIMIT));
            if (req_valid[r] && !req_ready_s[r]) begin
                wait_cnt_d[r] = (wait_cnt_q[r] >= CNT_W'(STARVE_LIMIT)) ?
                                wait_cnt_q[r] : (wait_cnt_q[r] + CNT_W'(1));
            end else begin
                // Granted or idle: the wait is over.
                wait_cnt_d[r] = '0;
            end
        end
    end

    // Wait-counter registers.
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    // Pure round-robin: nobody is ever promoted.
    always_comb begin
        starved_s = '0;
    end
`endif

    // Grant scan: pass 0 visits starved requesters, pass 1 the rest, both in
    // round-robin order from rr_ptr. The k-th grant lands on write port k.
    // Conflict detection compares against addresses already placed on ports.
    always_comb begin : scan_comb
        int   grant_cnt;
        int   idx;
        int   last_idx;
        int   nxt;
        logic rr_hit;
        logic conflict;
        logic grant_now;

        req_ready_s = '0;
        wr_en_d     = '0;
        wr_addr_d   = '0;
        wr_data_d   = '0;
        grant_cnt   = 0;
        idx         = 0;
        last_idx    = 0;
        nxt         = 0;
        rr_hit      = 1'b0;
        conflict    = 1'b0;
        grant_now   = 1'b0;

        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < N_REQ; k++) begin
                idx = int'(rr_ptr_q) + k;
                idx = (idx >= N_REQ) ? (idx - N_REQ) : idx;
                for (int r = 0; r < N_REQ; r++) begin
                    conflict = 1'b0;
                    for (int p = 0; p < N_WRITE_PORTS; p++) begin
                        conflict = conflict | ((p < grant_cnt) && (wr_addr_d[p] == req_addr[r]));
                    end
                    grant_now = (r == idx) && req_valid[r] && !conflict &&
                                (grant_cnt < N_WRITE_PORTS) &&
                                ((pass == 0) ? starved_s[r] : !starved_s[r]);
                    for (int p = 0; p < N_WRITE_PORTS; p++) begin
                        wr_en_d[p]   = wr_en_d[p] | (grant_now && (p == grant_cnt));
                        wr_addr_d[p] = (grant_now && (p == grant_cnt)) ? req_addr[r] : wr_addr_d[p];
                        wr_data_d[p] = (grant_now && (p == grant_cnt)) ? req_data[r] : wr_data_d[p];
                    end
                    req_ready_s[r] = req_ready_s[r] | grant_now;
                    // Only ordinary (non-starved) grants advance the pointer.
                    rr_hit    = rr_hit | (grant_now && (pass == 1));
                    last_idx  = (grant_now && (pass == 1)) ? r : last_idx;
                    grant_cnt = grant_cnt + (grant_now ? 1 : 0);
                end
            end
        end

        nxt      = last_idx + 1;
        nxt      = (nxt >= N_REQ) ? 0 : nxt;
        rr_ptr_d = rr_hit ? RR_W'(nxt) : rr_ptr_q;
    end

    // Pointer and write-port output registers.
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            rr_ptr_q  <= '0;
            wr_en_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign req_ready = req_ready_s;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

    regfile_wr_arb_chk #(
        .N_WRITE_PORTS (N_WRITE_PORTS),
        .PTR_WIDTH     (PTR_WIDTH)
    ) u_chk (
        .clk     (clk),
        .rst_aL  (rst_aL),
        .wr_en   (wr_en_q),
        .wr_addr (wr_addr_q)
    );

endmodule

// -----------------------------------------------------------------------------
// regfile_wr_arb_chk
//
// Property checker: no two enabled write ports carry the same address.
// Ports: clk, rst_aL (check disabled in reset), wr_en, wr_addr.
// -----------------------------------------------------------------------------
module regfile_wr_arb_chk #(
    parameter int N_WRITE_PORTS = 2,
    parameter int PTR_WIDTH     = 5
) (
    input logic                                    clk,
    input logic                                    rst_aL,
    input logic [N_WRITE_PORTS-1:0]                wr_en,
    input logic [N_WRITE_PORTS-1:0][PTR_WIDTH-1:0] wr_addr
);

    function automatic logic addr_dup(
        input logic [N_WRITE_PORTS-1:0]                en,
        input logic [N_WRITE_PORTS-1:0][PTR_WIDTH-1:0] addr
    );
        logic dup;
        dup = 1'b0;
        for (int a = 0; a < N_WRITE_PORTS; a++) begin
            for (int b = a + 1; b < N_WRITE_PORTS; b++) begin
                dup = dup | (en[a] && en[b] && (addr[a] == addr[b]));
            end
        end
        return dup;
    endfunction

    logic dup_s;

    // Duplicate-address detector feeding the property.
    always_comb begin
        dup_s = addr_dup(wr_en, wr_addr);
    end

    a_distinct_addr: assert property (@(posedge clk) disable iff (!rst_aL) !dup_s);

endmodule

// File: tb/tb_regfile_wr_arb.sv
// -----------------------------------------------------------------------------
// tb_regfile_wr_arb
//
// Directed, table-driven bench for regfile_wr_arb (N_REQ=4, 2 write ports,
// 32 entries x 32 bits). Each table row holds one cycle of requests, the
// expected combinational req_ready, and the expected registered write ports
// after the following rising edge. Hand-written sequences cover the mid-cycle
// reset and (when REGFILE_WR_ARB_STARVE_EN is defined) starvation promotion.
// A tiny regfile model records committed writes for the same-address check.
// -----------------------------------------------------------------------------
module tb_regfile_wr_arb;

    typedef struct packed {
        logic [3:0]        valid;
        logic [3:0][4:0]   addr;
        logic [3:0][31:0]  data;
        logic [3:0]        ready;
        logic [1:0]        en;
        logic [1:0][4:0]   waddr;
        logic [1:0][31:0]  wdata;
    } vec_t;

    localparam int NV = 13;

    logic             clk;
    logic             rst_aL;
    logic [3:0]       req_valid;
    logic [3:0][4:0]  req_addr;
    logic [3:0][31:0] req_data;
    logic [3:0]       req_ready;
    logic [1:0]       wr_en;
    logic [1:0][4:0]  wr_addr;
    logic [1:0][31:0] wr_data;

    logic [31:0]      rf [32];
    vec_t             vecs [NV];
    int               checks;
    int               failures;

    regfile_wr_arb #(
        .ENTRY_WIDTH   (32),
        .N_ENTRIES     (32),
        .N_REQ         (4),
        .N_WRITE_PORTS (2),
        .STARVE_LIMIT  (2)
    ) dut (
        .clk       (clk),
        .rst_aL    (rst_aL),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Regfile model: commits registered writes on the next rising edge.
    always @(posedge clk) begin
        if (rst_aL) begin
            for (int k = 0; k < 2; k++) begin
                if (wr_en[k]) rf[wr_addr[k]] <= wr_data[k];
            end
        end
    end

    function automatic vec_t mk(input logic [3:0] v, input logic [19:0] a,
                                input logic [127:0] d, input logic [3:0] rdy,
                                input logic [1:0] en, input logic [9:0] wa,
                                input logic [63:0] wd);
        vec_t t;
        t.valid = v;  t.addr = a;  t.data = d;
        t.ready = rdy; t.en = en; t.waddr = wa; t.wdata = wd;
        return t;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [19:0] a, input logic [127:0] d);
        req_valid = v;
        req_addr  = a;
        req_data  = d;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_aL   = 1'b0;
        drive(4'b0000, 20'd0, 128'd0);

        // addr concat order {a3,a2,a1,a0}; data {d3,d2,d1,d0}; ports {p1,p0}
        vecs[0]  = mk(4'b0001, {5'd0, 5'd0, 5'd0, 5'd5}, {32'd0, 32'd0, 32'd0, 32'hA5A5A5A5},
                      4'b0001, 2'b01, {5'd0, 5'd5}, {32'd0, 32'hA5A5A5A5});
        vecs[1]  = mk(4'b0000, 20'd0, 128'd0, 4'b0000, 2'b00, 10'd0, 64'd0);
        vecs[2]  = mk(4'b1000, {5'd12, 5'd0, 5'd0, 5'd0}, {32'h33, 32'd0, 32'd0, 32'd0},
                      4'b1000, 2'b01, {5'd0, 5'd12}, {32'd0, 32'h33});
        vecs[3]  = mk(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, {32'h103, 32'h102, 32'h101, 32'h100},
                      4'b0011, 2'b11, {5'd2, 5'd1}, {32'h101, 32'h100});
        vecs[4]  = mk(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, {32'h103, 32'h102, 32'h101, 32'h100},
                      4'b1100, 2'b11, {5'd4, 5'd3}, {32'h103, 32'h102});
        vecs[5]  = mk(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, {32'h103, 32'h102, 32'h101, 32'h100},
                      4'b0011, 2'b11, {5'd2, 5'd1}, {32'h101, 32'h100});
        vecs[6]  = mk(4'b1000, {5'd4, 5'd3, 5'd2, 5'd1}, {32'h103, 32'h102, 32'h101, 32'h100},
                      4'b1000, 2'b01, {5'd0, 5'd4}, {32'd0, 32'h103});
        vecs[7]  = mk(4'b0111, {5'd0, 5'd9, 5'd7, 5'd7}, {32'd0, 32'h99, 32'h22, 32'h11},
                      4'b0101, 2'b11, {5'd9, 5'd7}, {32'h99, 32'h11});
        vecs[8]  = mk(4'b0010, {5'd0, 5'd9, 5'd7, 5'd7}, {32'd0, 32'h99, 32'h22, 32'h11},
                      4'b0010, 2'b01, {5'd0, 5'd7}, {32'd0, 32'h22});
        vecs[9]  = mk(4'b0000, 20'd0, 128'd0, 4'b0000, 2'b00, 10'd0, 64'd0);
        vecs[10] = mk(4'b1111, {5'd0, 5'd0, 5'd3, 5'd0}, {32'hBB, 32'hAA, 32'hDD, 32'hCC},
                      4'b0110, 2'b11, {5'd3, 5'd0}, {32'hDD, 32'hAA});
        vecs[11] = mk(4'b1001, {5'd0, 5'd0, 5'd3, 5'd0}, {32'hBB, 32'hAA, 32'hDD, 32'hCC},
                      4'b1000, 2'b01, {5'd0, 5'd0}, {32'd0, 32'hBB});
        vecs[12] = mk(4'b0001, {5'd0, 5'd0, 5'd3, 5'd0}, {32'hBB, 32'hAA, 32'hDD, 32'hCC},
                      4'b0001, 2'b01, {5'd0, 5'd0}, {32'd0, 32'hCC});

        // Reset state.
        #2;
        chk("rst_wr_en",   128'(wr_en),     128'd0);
        chk("rst_wr_addr", 128'(wr_addr),   128'd0);
        chk("rst_wr_data", 128'(wr_data),   128'd0);
        chk("rst_ready",   128'(req_ready), 128'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_aL = 1'b1;

        // Table: drive at negedge, check ready, then check ports after the edge.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].valid, vecs[i].addr, vecs[i].data);
            #1;
            chk($sformatf("row%0d_ready", i), 128'(req_ready), 128'(vecs[i].ready));
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_wr_en", i),   128'(wr_en),   128'(vecs[i].en));
            chk($sformatf("row%0d_wr_addr", i), 128'(wr_addr), 128'(vecs[i].waddr));
            chk($sformatf("row%0d_wr_data", i), 128'(wr_data), 128'(vecs[i].wdata));
        end
        // Same-address ordering: the later write of entry 7 wins.
        chk("rf7_final", 128'(rf[7]), 128'h22);

        // Mid-cycle reset with a registered write live and a grant pending (rr_ptr=1).
        @(negedge clk);
        drive(4'b0001, {5'd0, 5'd0, 5'd0, 5'd5}, {96'd0, 32'h55});
        #1;
        chk("rstmid_ready", 128'(req_ready), 128'b0001);
        rst_aL = 1'b0;
        #1;
        chk("rstmid_wr_en",   128'(wr_en),   128'd0);
        chk("rstmid_wr_addr", 128'(wr_addr), 128'd0);
        chk("rstmid_wr_data", 128'(wr_data), 128'd0);
        drive(4'b0000, 20'd0, 128'd0);
        #1;
        rst_aL = 1'b1;
        @(posedge clk);
        #1;
        chk("rstmid_no_ghost", 128'(wr_en), 128'd0);
        // rr_ptr must be back at 0: requesters 0 and 1 win.
        @(negedge clk);
        drive(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, {32'h4, 32'h3, 32'h2, 32'h1});
        #1;
        chk("rstmid_rr0_ready", 128'(req_ready), 128'b0011);
        @(posedge clk);
        #1;
        chk("rstmid_rr0_wr_addr", 128'(wr_addr), 128'({5'd2, 5'd1}));

`ifdef REGFILE_WR_ARB_STARVE_EN
        // Starvation: req3 (addr 7) loses two conflicts, then jumps the queue.
        @(negedge clk);
        rst_aL = 1'b0;
        drive(4'b0000, 20'd0, 128'd0);
        #1;
        rst_aL = 1'b1;
        @(negedge clk);
        drive(4'b1001, {5'd7, 5'd7, 5'd7, 5'd7}, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        #1;
        chk("starve_c1_ready", 128'(req_ready), 128'b0001);
        @(negedge clk);
        req_valid = 4'b1010;
        #1;
        chk("starve_c2_ready", 128'(req_ready), 128'b0010);
        @(negedge clk);
        req_valid = 4'b1100;
        #1;
        chk("starve_c3_ready", 128'(req_ready), 128'b1000);
        @(posedge clk);
        #1;
        chk("starve_c3_wr_en",   128'(wr_en),   128'b01);
        chk("starve_c3_wr_data", 128'(wr_data), 128'({32'd0, 32'hA3}));
        // Counter cleared and rr_ptr held at 2: req2 now wins over req3.
        @(negedge clk);
        #1;
        chk("starve_c4_ready", 128'(req_ready), 128'b0100);
`endif

        @(negedge clk);
        drive(4'b0000, 20'd0, 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arb.md
Name: regfile_wr_arb

Overview:
- Round-robin arbiter that shares the N_WRITE_PORTS write ports of the register file among N_REQ writeback requesters (functional units, load return, etc.).
- Accepts valid/ready write requests and grants up to N_WRITE_PORTS per cycle.
- Never grants two writes to the same address in one cycle, so the regfile's distinct-address rule always holds.
- Drives the regfile's wr_en/wr_addr/wr_data from registers: one cycle of latency from acceptance.

Parameters:
- ENTRY_WIDTH, 32, data width of one register entry.
- N_ENTRIES, 32, number of regfile entries; PTR_WIDTH = $clog2(N_ENTRIES) (localparam).
- N_REQ, 4, number of writeback requesters.
- N_WRITE_PORTS, 2, regfile write ports driven; must be 1 <= N_WRITE_PORTS <= N_REQ.
- STARVE_LIMIT, 8, wait threshold in cycles; used only with the optional feature.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst_aL  input  1  asynchronous, active-low reset.
- req_valid  input  [N_REQ-1:0]  requester i has a write pending.
- req_addr  input  [N_REQ-1:0][PTR_WIDTH-1:0]  destination entry per requester.
- req_data  input  [N_REQ-1:0][ENTRY_WIDTH-1:0]  write data per requester.
- req_ready  output  [N_REQ-1:0]  grant; a transfer occurs when req_valid[i] && req_ready[i] at a rising edge of clk.
- wr_en  output  [N_WRITE_PORTS-1:0]  to regfile wr_en (registered).
- wr_addr  output  [N_WRITE_PORTS-1:0][PTR_WIDTH-1:0]  to regfile wr_addr (registered).
- wr_data  output  [N_WRITE_PORTS-1:0][ENTRY_WIDTH-1:0]  to regfile wr_data (registered).

Behaviour:
- Reset (async, rst_aL=0):
  - wr_en, wr_addr and wr_data all 0; rr_ptr = 0; starvation counters = 0.
  - req_ready is combinational and therefore 0 for every i with req_valid[i]=0.
  - Any write registered but not yet consumed is dropped.
- State:
  - rr_ptr, a $clog2(N_REQ)-bit register holding the highest-priority requester index.
  - Output registers for each write port.
  - Starvation counters (optional feature only).
- Grant scan, combinational, each cycle:
  - Visit requesters in order rr_ptr, rr_ptr+1, ..., wrapping mod N_REQ.
  - Requester i is granted iff req_valid[i]=1, fewer than N_WRITE_PORTS grants have been made so far, and req_addr[i] differs from every address already granted this cycle.
  - A requester skipped for an address conflict or for lack of ports keeps req_ready=0. It must hold valid/addr/data stable until granted (standard valid/ready rules).
  - Scanning continues past a conflicting requester, so later requesters may still be granted.
- Handshake timing:
  - req_ready may depend combinationally on req_valid and req_addr of all requesters.
  - Requesters must not derive req_valid from req_ready.
- Port assignment:
  - The k-th grant in scan order uses write port k.
  - At the next edge, port k registers wr_en=1 plus that requester's addr and data.
  - Ports with no grant register wr_en=0, wr_addr=0, wr_data=0.
- Latency: exactly 1 cycle from the accepting edge to wr_en visible at the regfile; the regfile commits it on the following edge.
- Pointer update:
  - If at least one grant occurs, rr_ptr <= (index of the last granted requester in scan order + 1) mod N_REQ.
  - If there are no grants, rr_ptr holds.
- Same-address ordering:
  - Of two valid requests to the same address, the one earlier in scan order writes first.
  - The other writes in a later cycle, and its value is the final one.
- Address 0 receives no special treatment (it is arbitrated like any other entry).
- All valid with N_REQ > N_WRITE_PORTS: round-robin guarantees every requester is granted within ceil(N_REQ/N_WRITE_PORTS) cycles, absent address conflicts.
- Assertion (disabled in reset): no two wr_en bits are set with equal wr_addr in the same cycle.

Optional Feature:
- Macro: REGFILE_WR_ARB_STARVE_EN.
- Defined:
  - Each requester has a saturating wait counter, $clog2(STARVE_LIMIT+1) bits wide.
  - The counter increments each cycle req_valid=1 && req_ready=0, and clears on grant or when req_valid=0.
  - A requester whose counter is >= STARVE_LIMIT is scanned before all others; ties among several starved requesters are broken by round-robin order.
  - rr_ptr updates as normal, considering only non-starved grants.
  - Counters reset to 0.
- Undefined: no counters; pure round-robin as above.

Test Plan (N_REQ=4, N_WRITE_PORTS=2, ENTRY_WIDTH=32, N_ENTRIES=32):
1. Reset, then req 0 valid (addr 5, data 0xA5A5A5A5) -> req_ready=4'b0001 the same cycle; next cycle wr_en=2'b01, wr_addr[0]=5, wr_data[0]=0xA5A5A5A5; following cycle wr_en=0.
2. All 4 valid with addrs 1,2,3,4 held from rr_ptr=0 -> grants {0,1}, then {2,3}, then {0,1}; ports fill in scan order; rr_ptr goes 0→2→0.
3. Req 0 and req 1 both addr 7 (data 0x11, 0x22), req 2 addr 9, rr_ptr=0 -> cycle 1 grants 0 and 2 (port0=7/0x11, port1=9); cycle 2 grants 1 (port0=7/0x22); the regfile ends with entry 7 = 0x22.
4. Grant issued, then rst_aL pulsed low mid-cycle before the next edge -> wr_en=0 immediately, rr_ptr=0, and the pending write never appears after release.
5. Only req 3 valid while rr_ptr=1 -> req 3 granted on port 0; rr_ptr becomes 0 (wrap-around).
6. With REGFILE_WR_ARB_STARVE_EN and STARVE_LIMIT=2, req 3 blocked by repeated addr conflicts for 2 cycles -> in the 3rd cycle req 3 is scanned first and granted on port 0, and its counter clears.
